ram_sweep: RTL and testbench

//   Parametrised single-port RAM. Generalises the fixed 16-bit x 512 RAM to any width and depth.

---
 rtl/ram_sweep.sv | 85 ++++++++
 tb/tb_ram_sweep.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_sweep.sv
// Parametrised single-port RAM with a hardware clear sweep after reset or on request,
// and an optional registered read port (READ_REG=1: one-cycle, read-first).
module ram_sweep #(
  parameter int              WIDTH    = 16,
  parameter int              ADDR_W   = 9,
  parameter logic [WIDTH-1:0] INIT_VAL = '0,
  parameter int              READ_REG = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  input  logic [WIDTH-1:0]  in,
  input  logic              clear,
  output logic [WIDTH-1:0]  out,
  output logic              busy
);

  localparam int              DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = '1;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic              wr_en;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      CLEAR: begin
        ptr_d = ptr_q + ADDR_W'(1);
        // The sweep ends on the compare against the last word, not on pointer wrap.
        if (ptr_q == LAST) state_d = IDLE;
      end
      IDLE: begin
        if (clear) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  assign busy  = (state_q == CLEAR);
  // A clear request in IDLE takes priority over a simultaneous write.
  assign wr_en = load & ~busy & ~clear;

  // NOTE: the storage array has no reset; the sweep is what defines its contents.
  always_ff @(posedge clk) begin
    if (busy)       mem[ptr_q]   <= INIT_VAL;
    else if (wr_en) mem[address] <= in;
  end

  generate
    if (READ_REG != 0) begin : g_reg_read
      logic [WIDTH-1:0] out_q;
      // Read-first: the old word is captured when the same edge writes that address.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    out_q <= INIT_VAL;
        else if (busy) out_q <= INIT_VAL;
        else           out_q <= mem[address];
      end
      assign out = out_q;
    end else begin : g_comb_read
      assign out = busy ? INIT_VAL : mem[address];
    end
  endgenerate

endmodule

// File: tb/tb_ram_sweep.sv
// Self-checking bench for ram_sweep: three instances (combinational read, registered read,
// registered read with a non-zero sweep value) driven in lockstep against an array model.
module tb_ram_sweep;

  localparam int          DEPTH = 512;
  localparam logic [15:0] INIT2 = 16'hA5A5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic        clear = 1'b0;
  logic [8:0]  address = '0;
  logic [15:0] din = '0;
  logic [15:0] out0, out1, out2;
  logic        busy0, busy1, busy2;

  int tests = 0;
  int failed = 0;

  // Reference model: word arrays plus a count of remaining sweep edges.
  logic [15:0] mref0 [DEPTH];
  logic [15:0] mref2 [DEPTH];
  int          busy_cnt;
  logic [15:0] exp_r1, exp_r2;

  always #5 clk = ~clk;

  ram_sweep #(.WIDTH(16), .ADDR_W(9), .INIT_VAL(16'h0000), .READ_REG(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .load(load), .address(address), .in(din),
    .clear(clear), .out(out0), .busy(busy0));
  ram_sweep #(.WIDTH(16), .ADDR_W(9), .INIT_VAL(16'h0000), .READ_REG(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .load(load), .address(address), .in(din),
    .clear(clear), .out(out1), .busy(busy1));
  ram_sweep #(.WIDTH(16), .ADDR_W(9), .INIT_VAL(INIT2), .READ_REG(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .load(load), .address(address), .in(din),
    .clear(clear), .out(out2), .busy(busy2));

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic fill_model();
    for (int i = 0; i < DEPTH; i++) begin
      mref0[i] = 16'h0000;
      mref2[i] = INIT2;
    end
  endtask

  task automatic model_reset();
    busy_cnt = DEPTH;
    fill_model();
    exp_r1 = 16'h0000;
    exp_r2 = INIT2;
  endtask

  task automatic check_all();
    logic eb;
    eb = (busy_cnt > 0);
    check("busy0", {15'b0, busy0}, {15'b0, eb});
    check("busy1", {15'b0, busy1}, {15'b0, eb});
    check("busy2", {15'b0, busy2}, {15'b0, eb});
    check("out0", out0, eb ? 16'h0000 : mref0[address]);
    check("out1", out1, exp_r1);
    check("out2", out2, exp_r2);
  endtask

  // Advance one rising edge, updating the model from the inputs seen at that edge.
  task automatic step();
    logic b;
    if (rst_n) begin
      b = (busy_cnt > 0);
      exp_r1 = b ? 16'h0000 : mref0[address];
      exp_r2 = b ? INIT2 : mref2[address];
      if (b) busy_cnt--;
      else if (clear) begin
        busy_cnt = DEPTH;
        fill_model();
      end else if (load) begin
        mref0[address] = din;
        mref2[address] = din;
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Count edges while busy; optionally pulse clear on sweep edge pulse_at.
  task automatic run_sweep(input int pulse_at, input bool_rand);
    int n;
    n = 0;
    while (busy0 === 1'b1 && n < 2000) begin
      clear = (n == pulse_at);
      if (bool_rand) address = 9'($urandom_range(0, DEPTH - 1));
      step();
      clear = 1'b0;
      n++;
    end
    check("sweep_len", 16'(n), 16'(DEPTH));
  endtask

  task automatic readback_all();
    load = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      address = 9'(a);
      #1;
      check("rb_comb", out0, mref0[a]);
      step();
    end
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all();

    // 1: sweep after reset with writes attempted throughout
    load = 1'b1;
    din  = 16'hFFFF;
    rst_n = 1'b1;
    run_sweep(-1, 1'b1);
    readback_all();

    // 2: write addr 0..19 with addr+1, then read back
    load = 1'b1;
    for (int a = 0; a < 20; a++) begin
      address = 9'(a);
      din = 16'(a + 1);
      step();
    end
    load = 1'b0;
    for (int a = 0; a < 20; a++) begin
      address = 9'(a);
      #1;
      check("wr_comb", out0, 16'(a + 1));
      step();
      check("wr_reg", out1, 16'(a + 1));
    end

    // 3: read-first on the registered port
    address = 9'd5;
    din = 16'h00AA;
    load = 1'b1;
    step();
    check("rf_old", out1, 16'h0006);
    load = 1'b0;
    step();
    check("rf_new", out1, 16'h00AA);

    // 4: clear wins over a simultaneous write
    address = 9'd3;
    din = 16'h1234;
    load = 1'b1;
    clear = 1'b1;
    step();
    clear = 1'b0;
    load = 1'b0;
    check("clr_busy", {15'b0, busy1}, 16'h0001);
    run_sweep(-1, 1'b0);
    address = 9'd3;
    #1;
    check("clr_addr3", out0, 16'h0000);
    readback_all();

    // 5: async reset at sweep edge 100
    clear = 1'b1;
    step();
    clear = 1'b0;
    repeat (100) step();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_busy", {15'b0, busy1}, 16'h0001);
    check("rst_out1", out1, 16'h0000);
    check("rst_out2", out2, INIT2);
    check_all();
    repeat (2) step();
    #2;
    rst_n = 1'b1;
    run_sweep(-1, 1'b0);

    // 6: clear during the sweep is ignored; INIT_VAL instance fills with A5A5
    load = 1'b1;
    for (int i = 0; i < 20; i++) begin
      address = 9'($urandom_range(0, DEPTH - 1));
      din = 16'($urandom);
      step();
    end
    load = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
    run_sweep(299, 1'b0);
    readback_all();
    check("a5_last", out2, INIT2);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
